systolic_sequencer: RTL

Control FSM for the 9×9 weight-stationary systolic array. It runs one tile per `start` pulse:
- requests a weight load from the w_clk-domain loader;
- clears the array accumulators;
- drives the skewed per-row enable `r_en` so that row i streams `num_vectors` vectors starting i cycles after row 0;
- waits for the pipeline to drain, then pulses `done`.

It replaces hand-written testbench stimulus for `r_en`, `s_reset` and `weight_write_enable`, and sits in s_clk between the tile scheduler and `top_module1`.

---
 rtl/cnn_ctrl_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/systolic_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared control definitions for the CNN array slice: sequencer states and
// default geometry reused by the array, loader and sequencer.
package cnn_ctrl_pkg;

    localparam int unsigned ARRAY_SIZE_DEF   = 9;
    localparam int unsigned VEC_W_DEF        = 8;
    localparam int unsigned FLUSH_CYCLES_DEF = 9;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        CLEAR,
        STREAM,
        FLUSH,
        DONE
    } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow level signals crossing into the local clock.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Per-tile control FSM for the weight-stationary systolic array: weight load
// handshake, accumulator clear, skewed row enables, pipeline flush, done.
module systolic_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE   = ARRAY_SIZE_DEF,
    parameter int unsigned VEC_W        = VEC_W_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic                  s_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [VEC_W-1:0]      num_vectors,
    input  logic                  w_done,
    output logic                  weight_write_enable,
    output logic                  acc_clr,
    output logic [ARRAY_SIZE-1:0] r_en,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = VEC_W + 1;
    localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

    seq_state_t            state, state_nxt;
    logic [VEC_W-1:0]      n_q;
    logic [CW-1:0]         cnt, cnt_nxt, stream_last;
    logic [FW-1:0]         fcnt, fcnt_nxt;
    logic                  w_done_s, w_done_d, w_rise;
    logic [ARRAY_SIZE-1:0] row_en;

    sync_2ff #(.WIDTH(1)) u_w_done_sync (
        .clk (s_clk),
        .rst (reset),
        .d   (w_done),
        .q   (w_done_s)
    );

    assign w_rise      = w_done_s & ~w_done_d;
    assign stream_last = {1'b0, n_q} + CW'(ARRAY_SIZE - 2);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fcnt_nxt  = fcnt;
        case (state)
            IDLE: begin
                if (start) state_nxt = (num_vectors == '0) ? DONE : WLOAD;
            end
            WLOAD: begin
                if (w_rise) state_nxt = CLEAR;
            end
            CLEAR: begin
                state_nxt = STREAM;
                cnt_nxt   = '0;
            end
            STREAM: begin
                if (cnt == stream_last) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt == FW'(FLUSH_CYCLES - 1)) state_nxt = DONE;
                else                               fcnt_nxt  = fcnt + 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row i is live while 0 <= cnt-i < N; below row i the subtraction wraps
    // to a value larger than any N, so one unsigned compare covers both bounds.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
        localparam logic [CW-1:0] ROW = CW'(i);
        assign row_en[i] = (cnt_nxt - ROW) < {1'b0, n_q};
    end

    always_ff @(posedge s_clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            n_q                 <= '0;
            cnt                 <= '0;
            fcnt                <= '0;
            w_done_d            <= 1'b0;
            weight_write_enable <= 1'b0;
            acc_clr             <= 1'b0;
            r_en                <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fcnt  <= fcnt_nxt;
            if (state == IDLE && start) n_q <= num_vectors;
            // Preloading the edge register on WLOAD entry hides a level that
            // was already high, so only a fresh low-to-high edge ends the wait.
            w_done_d <= (state != WLOAD && state_nxt == WLOAD) ? 1'b1 : w_done_s;
            weight_write_enable <= (state_nxt == WLOAD);
            acc_clr             <= (state_nxt == CLEAR);
            r_en                <= (state_nxt == STREAM) ? row_en : '0;
            busy                <= (state_nxt != IDLE);
            done                <= (state_nxt == DONE);
        end
    end

endmodule
